// File: rtl/pipeline_ctrl.sv
// Hazard sequencing for the 5-stage integer pipeline: register enables and flushes,
// load-use stalls, taken-redirect squashes, data-memory freezes and perf counters.
module pipeline_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      if_id_ir,
   input  logic [31:0]      id_ex_ir,
   input  logic [31:0]      ex_mem_ir,
   input  logic             branch_taken,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             id_ex_we,
   output logic             ex_mem_we,
   output logic             mem_wb_we,
   output logic             pc_sel,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_wb_flush,
   output logic [3:0]       stage_valid,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [5:0] OP_LW        = 6'b100011;
   localparam logic [5:0] OP_SW        = 6'b101011;
   localparam logic [5:0] OP_OPERATION = 6'b000000;
   localparam logic [5:0] OP_BEQZ      = 6'b000100;
   localparam logic [5:0] OP_BNEZ      = 6'b000101;
   localparam logic [5:0] OP_J         = 6'b000010;

   localparam int V_ID  = 0;
   localparam int V_EX  = 1;
   localparam int V_MEM = 2;
   localparam int V_WB  = 3;

   typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [3:0]        valid_q, valid_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic [5:0] if_id_op, id_ex_op, ex_mem_op;
   logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
   logic       mem_op, freeze, redirect, load_use, consumer_hit;

   assign if_id_op  = if_id_ir[31:26];
   assign id_ex_op  = id_ex_ir[31:26];
   assign ex_mem_op = ex_mem_ir[31:26];
   assign if_id_rs  = if_id_ir[25:21];
   assign if_id_rt  = if_id_ir[20:16];
   assign id_ex_rt  = id_ex_ir[20:16];

   always_comb begin
      consumer_hit = 1'b0;
      case (if_id_op)
         OP_OPERATION, OP_SW:     consumer_hit = (if_id_rs == id_ex_rt) || (if_id_rt == id_ex_rt);
         OP_LW, OP_BEQZ, OP_BNEZ: consumer_hit = (if_id_rs == id_ex_rt);
         default:                 consumer_hit = 1'b0;
      endcase
   end

   assign mem_op   = valid_q[V_MEM] && ((ex_mem_op == OP_LW) || (ex_mem_op == OP_SW));
   assign freeze   = mem_op && !dmem_ready;
   assign redirect = valid_q[V_EX] && branch_taken &&
                     ((id_ex_op == OP_BEQZ) || (id_ex_op == OP_BNEZ) || (id_ex_op == OP_J));
   assign load_use = valid_q[V_EX] && (id_ex_op == OP_LW) && valid_q[V_ID] &&
                     (id_ex_rt != 5'd0) && consumer_hit;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         valid_q     <= 4'b0000;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Next state: an outstanding access without ready holds us in MEM_WAIT
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:      state_d = freeze ? MEM_WAIT : RUN;
         MEM_WAIT: state_d = freeze ? MEM_WAIT : RUN;
         default:  state_d = RUN;
      endcase
   end

   // Outputs: priority freeze > redirect > load-use > advance; all quiet during reset
   always_comb begin
      dmem_req     = 1'b0;
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_we    = 1'b0;
      pc_sel       = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      if (!rst) begin
         dmem_req = mem_op;
         if (freeze) begin
            mem_wb_we    = 1'b1;
            mem_wb_flush = 1'b1;
         end else if (redirect) begin
            {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b11111;
            pc_sel      = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (load_use) begin
            {id_ex_we, ex_mem_we, mem_wb_we} = 3'b111;
            id_ex_flush = 1'b1;
         end else begin
            {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b11111;
         end
      end
   end

   always_comb begin
      valid_d     = valid_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (if_id_we)  valid_d[V_ID]  = !if_id_flush;
      if (id_ex_we)  valid_d[V_EX]  = !id_ex_flush && valid_q[V_ID];
      if (ex_mem_we) valid_d[V_MEM] = valid_q[V_EX];
      if (mem_wb_we) valid_d[V_WB]  = !mem_wb_flush && valid_q[V_MEM];
      if (!pc_we && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + 1'b1;
      if (pc_sel && (flush_cnt_q != {CNT_W{1'b1}}))
         flush_cnt_d = flush_cnt_q + 1'b1;
   end

   assign stage_valid = valid_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard-sequencing controller for the 5-stage integer pipeline. It generates the write enables and flushes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards that the forwarding path cannot cover, squashes wrong-path instructions on taken control transfers, and freezes the pipeline through multi-cycle data-memory accesses. It sits beside the forwarding unit, tracks per-stage valid bits, and keeps saturating stall and flush counters for performance analysis.

## Interface
- OP_LW, 6'b100011, load opcode (ir[31:26])
- OP_SW, 6'b101011, store opcode
- OP_OPERATION, 6'b000000, register-register ALU opcode (rs=[25:21], rt=[20:16], rd=[15:11])
- OP_BEQZ, 6'b000100, branch-if-zero opcode (tests rs)
- OP_BNEZ, 6'b000101, branch-if-nonzero opcode (tests rs)
- OP_J, 6'b000010, unconditional jump
- CNT_W, 16, width of performance counters

- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- if_id_ir  in  32  instruction in IF/ID
- id_ex_ir  in  32  instruction in ID/EX
- ex_mem_ir  in  32  instruction in EX/MEM
- branch_taken  in  1  EX-stage outcome for the id_ex instruction (1 = redirect; always 1 for OP_J)
- dmem_ready  in  1  data memory completes the current access this cycle
- dmem_req  out  1  data-memory access request for the EX/MEM instruction
- pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1 each  register load enables
- pc_sel  out  1  1 = PC loads the branch/jump target
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (NOP, valid=0) instead of upstream data
- stage_valid  out  4  {wb, mem, ex, id} valid bits
- stall_cnt  out  CNT_W  cycles with pc_we=0 after reset
- flush_cnt  out  CNT_W  taken redirects

## Operation
- The FSM has two states: RUN and MEM_WAIT.
- Memory access: mem_op = stage_valid[mem] & (ex_mem opcode is OP_LW or OP_SW).
  - dmem_req = mem_op in both states.
  - Completion occurs when dmem_req & dmem_ready.
  - If mem_op & !dmem_ready: FREEZE.
    - pc_we, if_id_we, id_ex_we and ex_mem_we = 0.
    - mem_wb_we = 1 with mem_wb_flush = 1.
    - The FSM enters or stays in MEM_WAIT.
  - On completion in MEM_WAIT, the FSM returns to RUN and normal advance occurs in that same cycle.
- Load-use hazard:
  - Condition: stage_valid[ex] & id_ex opcode OP_LW & stage_valid[id] & (id_ex rt != 0), and id_ex rt matches a consumer register in if_id:
    - rs or rt for OP_OPERATION, OP_SW and OP_LW (rs only for OP_LW);
    - rs for OP_BEQZ and OP_BNEZ.
  - Response: pc_we = 0, if_id_we = 0, id_ex_we = 1 with id_ex_flush = 1. EX/MEM and MEM/WB advance.
- Taken redirect:
  - Condition: stage_valid[ex] & id_ex opcode in {OP_BEQZ, OP_BNEZ, OP_J} & branch_taken.
  - Response: pc_sel = 1, pc_we = 1, if_id_flush = 1, id_ex_flush = 1, and all stages advance. flush_cnt increments.
- Priority: FREEZE > redirect > load-use > normal advance.
  - Redirect suppresses the load-use stall, because the consumer is squashed.
  - During FREEZE, redirect and load-use are not acted on. They are re-evaluated each cycle from the frozen registers.
- Normal advance: all we = 1, no flush, pc_sel = 0.
- Valid bits follow register enables:
  - On a stage load, a flushed stage becomes 0; otherwise it copies the upstream valid bit.
  - IF is always valid.
  - Without a load, a stage holds its valid bit.
- Counters are saturating. stall_cnt increments in every cycle with pc_we = 0 while not in reset.

## Timing
- While rst is high, all outputs are 0: we, flush, pc_sel, dmem_req, stage_valid, counters. The FSM is in RUN.
- The first clk edge after reset deassertion advances the pipeline.
- All control outputs are combinational from registered state and the current inputs. They act on the next clk edge.
- Load-use costs exactly 1 bubble. On the following cycle the LW is in EX/MEM, and forwarding covers the dependence.
- A taken redirect costs 2 bubbles. Resolution occurs in EX.
- A zero-wait memory (dmem_ready = 1 in the request cycle) costs no stall. Each additional wait cycle adds exactly 1 frozen cycle.
- dmem_ready while dmem_req = 0 is ignored.
- Reset asserted mid-MEM_WAIT returns the FSM to RUN and clears the valid bits. dmem_req drops immediately.

## Test plan
- Reset release, followed by 5 independent OP_OPERATION instructions: all we = 1 every cycle; stage_valid = 4'b1111 by the 4th edge; stall_cnt = 0.
- LW r3 in id_ex, and OP_OPERATION using rs = r3 in if_id: exactly 1 cycle with pc_we = 0 and id_ex_flush = 1; stall_cnt = 1. Repeating with rt = r0 produces no stall.
- BEQZ in id_ex with branch_taken = 1, and LW-dependent consumer in if_id: pc_sel = 1, if_id_flush = id_ex_flush = 1, pc_we = 1; flush_cnt = 1; stall_cnt unchanged.
- LW in ex_mem with dmem_ready low for 3 cycles: dmem_req held for 4 cycles; 3 FREEZE cycles, each with mem_wb_flush = 1; stall_cnt = 3; RUN on the 4th cycle.
- Taken OP_J in id_ex while SW in ex_mem waits 2 cycles: no pc_sel during the wait; pc_sel = 1 in the completion cycle; flush_cnt = 1.
- rst pulse during MEM_WAIT: dmem_req = 0 and stage_valid = 0 in the same cycle; after release, the FSM is in RUN and the counters read 0.
